// File: rtl/primrec_seq_pkg.sv
// Shared definitions for the primitive-recursion sequencer: default widths,
// watchdog limit and the FSM state encoding.
package primrec_seq_pkg;

    localparam int DEFAULT_BW       = 16;
    localparam int DEFAULT_WW       = 8;
    localparam int DEFAULT_MAX_WAIT = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

endpackage

// File: rtl/primrec_seq_if.sv
// Parent and child ST/RD handshakes of the sequencer bundled in one interface.
// The slave side is the sequencer itself; the master side is its environment.
interface primrec_seq_if import primrec_seq_pkg::*; #(
    parameter int BW = DEFAULT_BW
);
    logic          ST;
    logic [BW-1:0] IN0;
    logic [BW-1:0] IN1;
    logic          RD;
    logic [BW-1:0] RES;
    logic          ERR;

    logic          H_ST;
    logic          H_RD;
    logic [BW-1:0] H_RES;
    logic [BW-1:0] H_IN0;
    logic [BW-1:0] H_IN1;
    logic [BW-1:0] H_IN2;

    modport master (
        output ST, IN0, IN1, H_RD, H_RES,
        input  RD, RES, ERR, H_ST, H_IN0, H_IN1, H_IN2
    );

    modport slave (
        input  ST, IN0, IN1, H_RD, H_RES,
        output RD, RES, ERR, H_ST, H_IN0, H_IN1, H_IN2
    );

endinterface

// File: rtl/primrec_seq_watchdog.sv
// Handshake watchdog: counts waiting cycles and flags when the limit is reached.
module hs_watchdog import primrec_seq_pkg::*; #(
    parameter int WW       = DEFAULT_WW,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [WW-1:0] LIMIT = WW'(MAX_WAIT);

    logic [WW-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (RST || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/primrec_seq.sv
// Primitive-recursion sequencer: f(x,0)=x, f(x,i+1)=h(x,i,f(x,i)), with h
// evaluated by an external child block over a second ST/RD handshake.
module primrec_seq import primrec_seq_pkg::*; #(
    parameter int BW       = DEFAULT_BW,
    parameter int WW       = DEFAULT_WW,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic         CLK,
    input  logic         RST,
    primrec_seq_if.slave bus
);

    state_t        r_state;
    state_t        w_stateNext;
    logic          r_stOld;
    logic [BW-1:0] r_x,   w_xNext;
    logic [BW-1:0] r_n,   w_nNext;
    logic [BW-1:0] r_acc, w_accNext;
    logic [BW-1:0] r_cnt, w_cntNext;
    logic [BW-1:0] r_res, w_resNext;
    logic          r_rd,  w_rdNext;
    logic          r_err, w_errNext;
    logic          r_hSt, w_hStNext;
    logic          w_stRise;
    logic          w_wdClear;
    logic          w_wdEnable;
    logic          w_wdExpired;

    hs_watchdog #(
        .WW       (WW),
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .CLK       (CLK),
        .RST       (RST),
        .i_clear   (w_wdClear),
        .i_enable  (w_wdEnable),
        .o_expired (w_wdExpired)
    );

    // The edge detector keeps tracking ST through reset so a held ST cannot fire afterwards.
    always_ff @(posedge CLK) begin
        r_stOld <= bus.ST;
    end

    assign w_stRise = bus.ST & ~r_stOld;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_xNext     = r_x;
        w_nNext     = r_n;
        w_accNext   = r_acc;
        w_cntNext   = r_cnt;
        w_resNext   = r_res;
        w_rdNext    = r_rd;
        w_errNext   = r_err;
        w_hStNext   = r_hSt;
        w_wdClear   = 1'b0;
        w_wdEnable  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_stRise) begin
                    w_xNext     = bus.IN0;
                    w_nNext     = bus.IN1;
                    w_accNext   = bus.IN0;
                    w_cntNext   = '0;
                    w_rdNext    = 1'b0;
                    w_errNext   = 1'b0;
                    w_stateNext = CHECK;
                end
            end
            CHECK: begin
                if (r_cnt == r_n) begin
                    w_resNext   = r_acc;
                    w_rdNext    = 1'b1;
                    w_stateNext = IDLE;
                end else begin
                    w_hStNext   = 1'b1;
                    w_wdClear   = 1'b1;
                    w_stateNext = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.H_RD) begin
                    w_hStNext   = 1'b0;
                    w_wdClear   = 1'b1;
                    w_stateNext = WAIT_HI;
                end else if (w_wdExpired) begin
                    w_errNext   = 1'b1;
                    w_resNext   = r_acc;
                    w_hStNext   = 1'b0;
                    w_rdNext    = 1'b1;
                    w_stateNext = IDLE;
                end else begin
                    w_wdEnable  = 1'b1;
                end
            end
            WAIT_HI: begin
                if (bus.H_RD) begin
                    w_accNext   = bus.H_RES;
                    w_cntNext   = r_cnt + 1'b1;
                    w_stateNext = CHECK;
                end else if (w_wdExpired) begin
                    w_errNext   = 1'b1;
                    w_resNext   = r_acc;
                    w_hStNext   = 1'b0;
                    w_rdNext    = 1'b1;
                    w_stateNext = IDLE;
                end else begin
                    w_wdEnable  = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x   <= '0;
            r_n   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_res <= '0;
            r_rd  <= 1'b1;
            r_err <= 1'b0;
            r_hSt <= 1'b0;
        end else begin
            r_x   <= w_xNext;
            r_n   <= w_nNext;
            r_acc <= w_accNext;
            r_cnt <= w_cntNext;
            r_res <= w_resNext;
            r_rd  <= w_rdNext;
            r_err <= w_errNext;
            r_hSt <= w_hStNext;
        end
    end

    // Child operands come straight from the working registers.
    assign bus.RD    = r_rd;
    assign bus.RES   = r_res;
    assign bus.ERR   = r_err;
    assign bus.H_ST  = r_hSt;
    assign bus.H_IN0 = r_x;
    assign bus.H_IN1 = r_cnt;
    assign bus.H_IN2 = r_acc;

endmodule
